// File: rtl/rom_sweep_ctrl.sv
// Sweeps an inclusive, wrapping address range of a 16x4 combinational ROM and
// streams each (address, data) pair out on valid/ready with a running checksum.
module rom_sweep_ctrl #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] first_addr,
    input  logic [3:0] last_addr,
    output logic [3:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_addr,
    output logic [3:0] out_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);

    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 8;
    localparam logic [CW-1:0] DWELL_INIT = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   dwell_cnt;
    logic [AW-1:0]   last_q;
    logic            handshake;
    logic            busy_nx;
    logic            done_nx;
    logic            valid_nx;

    assign handshake = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SETTLE;
            SETTLE:  if (dwell_cnt == '0) state_nx = EMIT;
            EMIT: begin
                if (handshake) begin
                    state_nx = (rom_addr == last_q) ? DONE : SETTLE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they register in step with it
    always_comb begin
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        valid_nx = 1'b0;
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state_nx == DONE);
        valid_nx = (state_nx == EMIT);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            last_q    <= '0;
            dwell_cnt <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            busy      <= busy_nx;
            done      <= done_nx;
            out_valid <= valid_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        last_q    <= last_addr;
                        rom_addr  <= first_addr;
                        checksum  <= '0;
                        dwell_cnt <= DWELL_INIT;
                    end
                end
                SETTLE: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - CW'(1);
                    end else begin
                        out_data <= rom_data;
                        out_addr <= rom_addr;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        checksum <= checksum + SW'(out_data);
                        if (rom_addr != last_q) begin
                            rom_addr  <= rom_addr + AW'(1);
                            dwell_cnt <= DWELL_INIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_sweep_ctrl.sv
// Bench for rom_sweep_ctrl: two instances (DWELL=1 and DWELL=3) checked every
// cycle against a beat-level model, plus directed literal expectations.
module tb_rom_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rom_mode = 1'b0;
    logic [3:0] first_a = '0;
    logic [3:0] last_a = '0;
    logic       start_v [2];
    logic       ready_v [2];
    logic [3:0] a_rom   [2];
    logic [3:0] a_addr  [2];
    logic [3:0] a_data  [2];
    logic [3:0] rdat    [2];
    logic       a_valid [2];
    logic       a_busy  [2];
    logic       a_done  [2];
    logic [7:0] a_sum   [2];

    int n_chk = 0;
    int n_pass = 0;
    int cnt = 0;

    // Beat-level model state, one slot per instance
    logic       m_busy [2], m_valid [2], m_done [2], pv [2];
    logic [3:0] m_cur [2], m_addr [2], m_data [2];
    logic [7:0] m_sum [2];
    int         m_rem [2], m_wait [2], adv [2];
    int         nrise [2], rise0 [2], rise1 [2], done_rel [2];
    logic [7:0] done_sum [2];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    assign rdat[0] = rom_mode ? (a_rom[0] ^ 4'hA) : a_rom[0];
    assign rdat[1] = rom_mode ? (a_rom[1] ^ 4'hA) : a_rom[1];

    rom_sweep_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .first_addr(first_a),
        .last_addr(last_a), .rom_addr(a_rom[0]), .rom_data(rdat[0]),
        .out_valid(a_valid[0]), .out_ready(ready_v[0]), .out_addr(a_addr[0]),
        .out_data(a_data[0]), .busy(a_busy[0]), .done(a_done[0]), .checksum(a_sum[0])
    );

    rom_sweep_ctrl #(.DWELL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .first_addr(first_a),
        .last_addr(last_a), .rom_addr(a_rom[1]), .rom_data(rdat[1]),
        .out_valid(a_valid[1]), .out_ready(ready_v[1]), .out_addr(a_addr[1]),
        .out_data(a_data[1]), .busy(a_busy[1]), .done(a_done[1]), .checksum(a_sum[1])
    );

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Per-cycle compare against the model, then advance the model on the inputs
    // the DUT will sample at the coming rising edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_done[i] = 1'b0; pv[i] = 1'b0;
                m_cur[i] = '0; m_addr[i] = '0; m_data[i] = '0; m_sum[i] = '0;
                m_rem[i] = 0; m_wait[i] = 0;
            end
            check($sformatf("d%0d.out_valid", i), a_valid[i], m_valid[i]);
            check($sformatf("d%0d.busy", i), a_busy[i], m_busy[i]);
            check($sformatf("d%0d.done", i), a_done[i], m_done[i]);
            check($sformatf("d%0d.rom_addr", i), a_rom[i], m_cur[i]);
            check($sformatf("d%0d.out_addr", i), a_addr[i], m_addr[i]);
            check($sformatf("d%0d.out_data", i), a_data[i], m_data[i]);
            check($sformatf("d%0d.checksum", i), a_sum[i], m_sum[i]);

            if (m_valid[i] && !pv[i]) begin
                if (nrise[i] == 0) rise0[i] = cnt - adv[i];
                if (nrise[i] == 1) rise1[i] = cnt - adv[i];
                nrise[i]++;
            end
            pv[i] = m_valid[i];
            if (m_done[i]) begin
                done_rel[i] = cnt - adv[i];
                done_sum[i] = m_sum[i];
            end

            if (rst_n) begin
                if (m_done[i]) begin
                    m_done[i] = 1'b0;
                    m_busy[i] = 1'b0;
                end else if (!m_busy[i]) begin
                    if (start_v[i]) begin
                        logic [3:0] span;
                        span = last_a - first_a;
                        m_busy[i] = 1'b1;
                        m_cur[i]  = first_a;
                        m_rem[i]  = int'(span) + 1;
                        m_wait[i] = (i == 0) ? 1 : 3;
                        m_sum[i]  = '0;
                        adv[i]    = cnt;
                        nrise[i]  = 0;
                    end
                end else if (m_valid[i]) begin
                    if (ready_v[i]) begin
                        m_sum[i]   = m_sum[i] + {4'b0, m_data[i]};
                        m_rem[i]   = m_rem[i] - 1;
                        m_valid[i] = 1'b0;
                        if (m_rem[i] == 0) begin
                            m_done[i] = 1'b1;
                        end else begin
                            m_cur[i]  = m_cur[i] + 4'd1;
                            m_wait[i] = (i == 0) ? 1 : 3;
                        end
                    end
                end else begin
                    m_wait[i] = m_wait[i] - 1;
                    if (m_wait[i] == 0) begin
                        m_valid[i] = 1'b1;
                        m_addr[i]  = m_cur[i];
                        m_data[i]  = rom_mode ? (m_cur[i] ^ 4'hA) : m_cur[i];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int i, input logic [3:0] f, input logic [3:0] l);
        first_a = f;
        last_a = l;
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 300 && !a_done[i]; k++) step();
        check($sformatf("d%0d.done_seen", i), a_done[i], 1);
        step();
    endtask

    task automatic check_reset_outputs(input int i);
        check($sformatf("rst d%0d.rom_addr", i), a_rom[i], 0);
        check($sformatf("rst d%0d.out_valid", i), a_valid[i], 0);
        check($sformatf("rst d%0d.out_addr", i), a_addr[i], 0);
        check($sformatf("rst d%0d.out_data", i), a_data[i], 0);
        check($sformatf("rst d%0d.busy", i), a_busy[i], 0);
        check($sformatf("rst d%0d.done", i), a_done[i], 0);
        check($sformatf("rst d%0d.checksum", i), a_sum[i], 0);
    endtask

    initial begin
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        ready_v[0] = 1'b1; ready_v[1] = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(0);
        check_reset_outputs(1);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("idle busy", a_busy[0], 0);

        // Full sweep, identity ROM
        launch(0, 4'h0, 4'hF);
        wait_done(0);
        check("full done cycle", done_rel[0], 33);
        check("full checksum", done_sum[0], 8'h78);
        check("full first valid", rise0[0], 2);
        check("full second valid", rise1[0], 4);
        check("checksum holds", a_sum[0], 8'h78);

        // Backpressure at beat 0x5
        launch(0, 4'h0, 4'hF);
        for (int k = 0; k < 100 && !(a_valid[0] && a_addr[0] == 4'h5); k++) step();
        check("bp reached 5", a_addr[0], 4'h5);
        ready_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp valid", a_valid[0], 1);
            check("bp out_addr", a_addr[0], 4'h5);
            check("bp out_data", a_data[0], 4'h5);
            check("bp rom_addr", a_rom[0], 4'h5);
            step();
        end
        ready_v[0] = 1'b1;
        wait_done(0);
        check("bp done cycle", done_rel[0], 36);
        check("bp checksum", done_sum[0], 8'h78);

        // Wrap and single beat
        launch(0, 4'hE, 4'h1);
        wait_done(0);
        check("wrap checksum", done_sum[0], 8'h1E);
        check("wrap done cycle", done_rel[0], 9);
        launch(0, 4'h7, 4'h7);
        wait_done(0);
        check("single checksum", done_sum[0], 8'h07);
        check("single done cycle", done_rel[0], 3);

        // Non-identity ROM contents
        rom_mode = 1'b1;
        launch(0, 4'h3, 4'h6);
        wait_done(0);
        check("xor rom checksum", done_sum[0], 8'h32);
        rom_mode = 1'b0;

        // DWELL=3 instance
        launch(1, 4'h2, 4'h3);
        wait_done(1);
        check("dwell3 first valid", rise0[1], 4);
        check("dwell3 second valid", rise1[1], 8);
        check("dwell3 done cycle", done_rel[1], 9);
        check("dwell3 checksum", done_sum[1], 8'h05);

        // Start while busy is ignored, then reset during SETTLE of beat 0x9
        launch(0, 4'h0, 4'hF);
        for (int k = 0; k < 100 && !(a_valid[0] && a_addr[0] == 4'h3); k++) step();
        check("busy start at 3", a_addr[0], 4'h3);
        first_a = 4'h8;
        last_a = 4'h8;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        for (int k = 0; k < 100 && !(a_rom[0] == 4'h9 && !a_valid[0]); k++) step();
        check("settle 9 rom_addr", a_rom[0], 4'h9);
        check("settle 9 sum", a_sum[0], 8'h24);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("post reset busy", a_busy[0], 0);
        check("post reset done", a_done[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
